// File: rtl/da_lut_array.sv
// Banked distributed-arithmetic lookup table: serial table load, then parallel reads from all banks.
// Optional per-word even parity storage and checking is enabled by defining LUT_PARITY_EN.
module da_lut_array #(
    parameter int NBANK = 8,
    parameter int AW    = 8,
    parameter int DW    = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DW-1:0]         ld_data,
    input  logic                  ld_last,
    output logic                  tbl_ready,
    output logic                  ld_err,
    input  logic                  rd_en,
    input  logic [NBANK*AW-1:0]   rd_addr,
    output logic [NBANK*DW-1:0]   rd_q,
    output logic                  rd_qvalid,
    output logic                  par_err
);

`ifdef LUT_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif
    localparam int CW    = AW + 4;
    localparam int DEPTH = 1 << AW;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBANK * DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    // Stored word: even parity bit (when enabled) above the data.
    function automatic logic [MW-1:0] enc_word(input logic [DW-1:0] d);
`ifdef LUT_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

`ifdef LUT_PARITY_EN
    function automatic logic par_bad(input logic [MW-1:0] w);
        return ^w;
    endfunction
`endif

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_ld_ready;
    logic                  r_tbl_ready;
    logic                  r_ld_err;
    logic [NBANK*AW-1:0]   r_rd_addr;
    logic                  r_rd_v1;
    logic [NBANK*DW-1:0]   r_rd_q;
    logic                  r_rd_qvalid;
    logic [MW-1:0]         w_bank_word [NBANK];
    logic                  w_accept;
    logic                  w_final;
    logic                  w_load_entry;
    logic                  w_rd_accept;

    assign w_accept     = ld_valid && r_ld_ready;
    assign w_final      = (r_cnt == LAST_IDX);
    assign w_load_entry = cfg_start && (r_state != LOAD);
    assign w_rd_accept  = rd_en && (r_state == READY);

    // Load sequencing FSM with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ld_ready  <= 1'b0;
            r_tbl_ready <= 1'b0;
            r_ld_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, READY: begin
                    if (w_load_entry) begin
                        r_state     <= LOAD;
                        r_cnt       <= '0;
                        r_ld_err    <= 1'b0;
                        r_ld_ready  <= 1'b1;
                        r_tbl_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        if (ld_last && w_final) begin
                            r_state     <= READY;
                            r_ld_ready  <= 1'b0;
                            r_tbl_ready <= 1'b1;
                        end else if (ld_last || w_final) begin
                            // Length disagreement: the word is still stored, the table is abandoned.
                            r_state    <= IDLE;
                            r_ld_ready <= 1'b0;
                            r_ld_err   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_ld_ready  <= 1'b0;
                    r_tbl_ready <= 1'b0;
                end
            endcase
        end
    end

    genvar b;
    generate
        for (b = 0; b < NBANK; b++) begin : g_bank
            logic [MW-1:0] r_mem [0:DEPTH-1];
            logic          w_we;

            assign w_we = w_accept && (r_cnt[CW-1:AW] == 4'(b));

            // Table storage is deliberately not reset.
            always_ff @(posedge clk) begin
                if (w_we) begin
                    r_mem[r_cnt[AW-1:0]] <= enc_word(ld_data);
                end
            end

            assign w_bank_word[b] = r_mem[r_rd_addr[b*AW +: AW]];
        end
    endgenerate

    // Two-stage read pipeline: address capture, then bank read into rd_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr   <= '0;
            r_rd_v1     <= 1'b0;
            r_rd_q      <= '0;
            r_rd_qvalid <= 1'b0;
        end else begin
            r_rd_v1     <= w_rd_accept;
            r_rd_qvalid <= r_rd_v1;
            if (w_rd_accept) begin
                r_rd_addr <= rd_addr;
            end
            if (r_rd_v1) begin
                for (int i = 0; i < NBANK; i++) begin
                    r_rd_q[i*DW +: DW] <= w_bank_word[i][DW-1:0];
                end
            end
        end
    end

`ifdef LUT_PARITY_EN
    logic [NBANK-1:0] w_bad;
    logic             r_par_err;

    for (b = 0; b < NBANK; b++) begin : g_par
        assign w_bad[b] = par_bad(w_bank_word[b]);
    end

    // Sticky parity flag, cleared when a new load begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if (w_load_entry) begin
            r_par_err <= 1'b0;
        end else if (r_rd_v1 && (|w_bad)) begin
            r_par_err <= 1'b1;
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

    assign ld_ready  = r_ld_ready;
    assign tbl_ready = r_tbl_ready;
    assign ld_err    = r_ld_err;
    assign rd_q      = r_rd_q;
    assign rd_qvalid = r_rd_qvalid;

endmodule

// File: tb/tb_da_lut_array.sv
// Directed bench for da_lut_array: load, parallel reads, length errors, reset mid-load, reload.
module tb_da_lut_array;
    localparam int NBANK = 8;
    localparam int AW    = 8;
    localparam int DW    = 20;
    localparam int NW    = NBANK * (1 << AW);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cfg_start;
    logic                ld_valid;
    logic                ld_ready;
    logic [DW-1:0]       ld_data;
    logic                ld_last;
    logic                tbl_ready;
    logic                ld_err;
    logic                rd_en;
    logic [NBANK*AW-1:0] rd_addr;
    logic [NBANK*DW-1:0] rd_q;
    logic                rd_qvalid;
    logic                par_err;

    int n_chk = 0;
    int n_err = 0;

    da_lut_array #(.NBANK(NBANK), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .tbl_ready(tbl_ready), .ld_err(ld_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_q(rd_q), .rd_qvalid(rd_qvalid),
        .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane b address = off + b.
    function automatic logic [NBANK*AW-1:0] addr_off(input int off);
        logic [NBANK*AW-1:0] a;
        for (int i = 0; i < NBANK; i++) a[i*AW +: AW] = AW'(off + i);
        return a;
    endfunction

    function automatic logic [NBANK*AW-1:0] addr_pat(input int j);
        logic [NBANK*AW-1:0] a;
        for (int i = 0; i < NBANK; i++) a[i*AW +: AW] = AW'((j * 37 + i * 11 + 3) % 256);
        return a;
    endfunction

    // Table was loaded with value = global index, so bank b word a holds b*256 + a.
    function automatic logic [NBANK*DW-1:0] exp_q(input logic [NBANK*AW-1:0] a);
        logic [NBANK*DW-1:0] q;
        for (int i = 0; i < NBANK; i++) q[i*DW +: DW] = DW'(i * 256 + int'(a[i*AW +: AW]));
        return q;
    endfunction

    task automatic load_words(input int n, input int last_at, input int cfg_at);
        for (int i = 0; i < n; i++) begin
            ld_valid  = 1'b1;
            ld_data   = DW'(i);
            ld_last   = (i == last_at);
            cfg_start = (i == cfg_at);
            tick();
        end
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        cfg_start = 1'b0;
    endtask

    task automatic single_read(input string tag, input int off);
        rd_en   = 1'b1;
        rd_addr = addr_off(off);
        tick();
        rd_en = 1'b0;
        chk({tag, "_lat1_qvalid"}, 256'(rd_qvalid), 256'(1'b0));
        tick();
        chk({tag, "_qvalid"}, 256'(rd_qvalid), 256'(1'b1));
        chk({tag, "_data"}, 256'(rd_q), 256'(exp_q(addr_off(off))));
    endtask

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        tick(); tick();
        chk("rst_tbl_ready", 256'(tbl_ready), 256'(1'b0));
        chk("rst_ld_ready", 256'(ld_ready), 256'(1'b0));
        chk("rst_ld_err", 256'(ld_err), 256'(1'b0));
        chk("rst_qvalid", 256'(rd_qvalid), 256'(1'b0));
        chk("rst_rd_q", 256'(rd_q), 256'(0));
        chk("rst_par_err", 256'(par_err), 256'(1'b0));
        rst_n = 1'b1;
        tick();

        // Read before any load is ignored.
        rd_en = 1'b1; rd_addr = addr_off(1);
        tick(); tick(); tick();
        rd_en = 1'b0;
        chk("pre_load_qvalid", 256'(rd_qvalid), 256'(1'b0));

        // Full load, value = index.
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        chk("load_ld_ready", 256'(ld_ready), 256'(1'b1));
        chk("load_tbl_ready", 256'(tbl_ready), 256'(1'b0));
        load_words(NW, NW - 1, -1);
        chk("full_tbl_ready", 256'(tbl_ready), 256'(1'b1));
        chk("full_ld_err", 256'(ld_err), 256'(1'b0));
        chk("full_ld_ready", 256'(ld_ready), 256'(1'b0));

        single_read("rd5", 5);

        // Back-to-back reads with ld_valid toggling.
        for (int t = 0; t < 6; t++) begin
            rd_en    = (t < 4);
            rd_addr  = addr_pat(t);
            ld_valid = t[0];
            ld_data  = DW'(t * 1000);
            tick();
            if (t >= 1 && t <= 4) begin
                chk($sformatf("b2b_qvalid_%0d", t - 1), 256'(rd_qvalid), 256'(1'b1));
                chk($sformatf("b2b_data_%0d", t - 1), 256'(rd_q), 256'(exp_q(addr_pat(t - 1))));
            end
        end
        rd_en = 1'b0; ld_valid = 1'b0;
        chk("hold_qvalid", 256'(rd_qvalid), 256'(1'b0));
        chk("hold_data", 256'(rd_q), 256'(exp_q(addr_pat(3))));
        tick();
        chk("hold_data2", 256'(rd_q), 256'(exp_q(addr_pat(3))));
        chk("par_clean", 256'(par_err), 256'(1'b0));

`ifdef LUT_PARITY_EN
        dut.g_bank[3].r_mem[5] = dut.g_bank[3].r_mem[5] ^ 21'd1;
        rd_en = 1'b1; rd_addr = addr_off(2);
        tick(); rd_en = 1'b0; tick();
        chk("par_err_set", 256'(par_err), 256'(1'b1));
        single_read("rd_after_par", 0);
        chk("par_err_sticky", 256'(par_err), 256'(1'b1));
`else
        chk("par_err_tied", 256'(par_err), 256'(1'b0));
`endif

        // Early ld_last on word 100.
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        chk("reload_par_clr", 256'(par_err), 256'(1'b0));
        load_words(101, 100, -1);
        chk("early_ld_err", 256'(ld_err), 256'(1'b1));
        chk("early_tbl_ready", 256'(tbl_ready), 256'(1'b0));
        chk("early_ld_ready", 256'(ld_ready), 256'(1'b0));
        rd_en = 1'b1; rd_addr = addr_off(5);
        tick(); tick(); tick();
        rd_en = 1'b0;
        chk("idle_rd_ignored", 256'(rd_qvalid), 256'(1'b0));
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        chk("cfg_clears_ld_err", 256'(ld_err), 256'(1'b0));
        chk("cfg_ld_ready", 256'(ld_ready), 256'(1'b1));

        // Reset at word 1000.
        load_words(1000, -1, -1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ld_ready", 256'(ld_ready), 256'(1'b0));
        chk("midrst_tbl_ready", 256'(tbl_ready), 256'(1'b0));
        chk("midrst_ld_err", 256'(ld_err), 256'(1'b0));
        chk("midrst_qvalid", 256'(rd_qvalid), 256'(1'b0));
        chk("midrst_rd_q", 256'(rd_q), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();
        rd_en = 1'b1; rd_addr = addr_off(7);
        tick(); tick(); tick();
        rd_en = 1'b0;
        chk("postrst_rd_ignored", 256'(rd_qvalid), 256'(1'b0));
        chk("postrst_tbl_ready", 256'(tbl_ready), 256'(1'b0));

        // Full reload; a cfg_start pulse at word 500 must be ignored.
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        load_words(NW, NW - 1, 500);
        chk("reload_tbl_ready", 256'(tbl_ready), 256'(1'b1));
        chk("reload_ld_err", 256'(ld_err), 256'(1'b0));
        single_read("rd_reload", 5);

        // Read in flight completes across cfg_start; later reads are ignored.
        rd_en = 1'b1; rd_addr = addr_off(40);
        tick();
        rd_en = 1'b0; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("inflight_qvalid", 256'(rd_qvalid), 256'(1'b1));
        chk("inflight_data", 256'(rd_q), 256'(exp_q(addr_off(40))));
        chk("inflight_tbl_ready", 256'(tbl_ready), 256'(1'b0));
        rd_en = 1'b1; rd_addr = addr_off(9);
        tick(); tick(); tick();
        rd_en = 1'b0;
        chk("load_rd_ignored", 256'(rd_qvalid), 256'(1'b0));

        // Final word without ld_last.
        load_words(NW, -1, -1);
        chk("nolast_ld_err", 256'(ld_err), 256'(1'b1));
        chk("nolast_tbl_ready", 256'(tbl_ready), 256'(1'b0));
        chk("nolast_ld_ready", 256'(ld_ready), 256'(1'b0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/da_lut_array.md
DA_LUT_ARRAY -- requirements
Module: da_lut_array

Interface
REQ-001 SHALL have parameter NBANK, default 8: number of independent lookup banks (1..16).
REQ-002 SHALL have parameter AW, default 8: address bits per bank (depth 2^AW words).
REQ-003 SHALL have parameter DW, default 20: data bits per word.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port cfg_start  input  1: one-cycle pulse that begins a table load.
REQ-007 SHALL have port ld_valid  input  1: load word valid.
REQ-008 SHALL have port ld_ready  output  1: load word accepted when ld_valid && ld_ready.
REQ-009 SHALL have port ld_data  input  DW: precomputed partial sum to store.
REQ-010 SHALL have port ld_last  input  1: marks the final load word.
REQ-011 SHALL have port tbl_ready  output  1: table loaded, reads permitted.
REQ-012 SHALL have port ld_err  output  1: sticky load-length error.
REQ-013 SHALL have port rd_en  input  1: read request, all banks in parallel.
REQ-014 SHALL have port rd_addr  input  NBANK*AW: bank b address at bits [b*AW +: AW].
REQ-015 SHALL have port rd_q  output  NBANK*DW: bank b data at bits [b*DW +: DW].
REQ-016 SHALL have port rd_qvalid  output  1: rd_q holds data for an accepted read.
REQ-017 SHALL have port par_err  output  1: sticky parity error (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, READY; reset state IDLE.
REQ-019 SHALL move IDLE->LOAD and READY->LOAD on cfg_start; cfg_start in LOAD SHALL be ignored.
REQ-020 SHALL clear the load counter, ld_err and par_err on entry to LOAD.
REQ-021 SHALL assert ld_ready only in LOAD; ld_ready SHALL NOT depend combinationally on ld_valid.
REQ-022 SHALL write each accepted word to bank cnt[AW+3:AW], word cnt[AW-1:0] (bank-major, address-minor), then increment cnt.
REQ-023 SHALL treat the word at cnt = NBANK*2^AW-1 as final; if accepted with ld_last=1, SHALL go to READY on the same edge.
REQ-024 SHALL, if ld_last=1 on a non-final word or ld_last=0 on the final word, still write that word, set ld_err, and go to IDLE.
REQ-025 SHALL drive tbl_ready = 1 only in READY.
REQ-026 SHALL ignore rd_en outside READY; no rd_qvalid results.
REQ-027 SHALL, for rd_en=1 in READY sampled at edge k, register rd_addr at k, read all banks at k+1, and present rd_q with rd_qvalid=1 after edge k+1 (latency 2, throughput 1/cycle).
REQ-028 SHALL hold rd_q at its last value when rd_qvalid=0.
REQ-029 SHALL complete a read in flight when cfg_start arrives, but later reads return only after reload.

Reset
REQ-030 SHALL on rst_n=0: state IDLE, cnt 0, ld_ready 0, tbl_ready 0, ld_err 0, par_err 0, rd_qvalid 0, rd_q 0, pipeline valids 0.
REQ-031 SHALL NOT reset table contents; after reset mid-load, tbl_ready SHALL stay 0 until a full reload completes.

Configuration
REQ-032 SHALL, with LUT_PARITY_EN defined, store DW+1 bits per word (even parity over ld_data), check each bank on read, and set par_err on the edge rd_qvalid rises if any bank mismatches.
REQ-033 SHALL, without LUT_PARITY_EN, store DW bits and tie par_err to 0.

Verification
REQ-034 Reset then cfg_start, 2048 words with value = index, ld_last on word 2047 -> tbl_ready=1 the cycle after word 2047, ld_err=0.
REQ-035 After load, rd_en with bank b address = 5+b for all b -> two cycles later rd_qvalid=1, bank b lane = b*256+5+b.
REQ-036 ld_last on word 100 -> ld_err=1, state IDLE, tbl_ready=0; next cfg_start clears ld_err.
REQ-037 rst_n low at word 1000 of a load -> all outputs per REQ-030 immediately; rd_en ignored until reload completes.
REQ-038 Back-to-back rd_en for 4 cycles with ld_valid toggling and no backpressure -> 4 consecutive rd_qvalid cycles, data in order.
REQ-039 With LUT_PARITY_EN, bench flips one stored bit in bank 3 word 5 and reads it -> par_err=1 and stays 1 until cfg_start; without the macro -> par_err=0.
